// File: rtl/led_arb_pkg.sv
// Shared types for the LED arbiter.
// State encoding and widths used by led_arbiter and rr_picker.
package led_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } led_arb_state_t;

endpackage

// File: rtl/led_arbiter_rr_picker.sv
// Round-robin winner selection for the LED arbiter.
// Search begins just after the last owner and wraps around.
module rr_picker
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [IW-1:0] idx;

    // first set request after the last owner wins
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((32'(last) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the board LED with hold and timeout tenure.
// Optional LED_ARB_SWITCH_OVERRIDE_EN adds a synchronized force-on switch.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int MAX_CYCLES  = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef LED_ARB_SWITCH_OVERRIDE_EN
    input  logic               switch,
`endif
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] led_val,
    output logic [NUM_REQ-1:0] grant,
    output logic               led,
    output logic               busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [IW-1:0] LAST_R = IW'(NUM_REQ - 1);

    led_arb_state_t     state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               led_q, led_d;

    logic [NUM_REQ-1:0] win;
    logic               win_valid;
    logic [IW-1:0]      win_idx;
    logic               release_now;
    logic               arb_led;
    logic               ovr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .win   (win),
        .valid (win_valid)
    );

`ifdef LED_ARB_SWITCH_OVERRIDE_EN
    logic [1:0] sync_q, sync_d;

    // two-flop synchronizer for the asynchronous switch
    always_comb begin
        sync_d = {sync_q[0], switch};
        ovr    = sync_q[1];
    end

    // synchronizer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign ovr = 1'b0;
`endif

    // one-hot winner to owner index
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // tenure ends after hold with request gone, or at the hard limit
    always_comb begin
        release_now = (cnt_q >= HOLD_C && !req[last_q]) ||
                      (cnt_q == MAX_C);
    end

    // next-state, tenure counter, grant and LED level
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        arb_led = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = '0;
                if (win_valid) begin
                    state_d = GRANT;
                    last_d  = win_idx;
                    cnt_d   = ONE_C;
                    grant_d = win;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    grant_d = '0;
                end else begin
                    cnt_d   = cnt_q + ONE_C;
                    arb_led = led_val[last_q];
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
        led_d = arb_led | ovr;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= LAST_R;
            cnt_q   <= '0;
            grant_q <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            led_q   <= led_d;
        end
    end

    assign grant = grant_q;
    assign led   = led_q;
    assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter (NUM_REQ=4, HOLD=4, MAX=10).
// Behavioural owner/tenure model plus directed literal checks.
module tb_led_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int MAX  = 10;

    logic         clk;
    logic         rst_n;
    logic         sw;
    logic [N-1:0] req;
    logic [N-1:0] led_val;
    logic [N-1:0] grant;
    logic         led;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner;
    int m_ten;
    int m_ptr;
    bit m_led;
    bit m_nl;
    bit m_s1;
    bit m_s2;
    int m_c;

    led_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD),
        .MAX_CYCLES  (MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef LED_ARB_SWITCH_OVERRIDE_EN
        .switch  (sw),
`endif
        .req     (req),
        .led_val (led_val),
        .grant   (grant),
        .led     (led),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Model: owner/tenure rules applied at each edge
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_ten   = 0;
                m_ptr   = N - 1;
                m_led   = 1'b0;
                m_s1    = 1'b0;
                m_s2    = 1'b0;
            end else begin
                m_nl = 1'b0;
                if (m_owner >= 0) begin
                    if ((m_ten >= HOLD && !req[m_owner]) || m_ten == MAX) begin
                        m_owner = -1;
                        m_ten   = 0;
                    end else begin
                        m_ten++;
                        m_nl = led_val[m_owner];
                    end
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        m_c = (m_ptr + k) % N;
                        if (m_owner < 0 && req[m_c]) begin
                            m_owner = m_c;
                            m_ptr   = m_c;
                            m_ten   = 1;
                        end
                    end
                end
`ifdef LED_ARB_SWITCH_OVERRIDE_EN
                m_nl = m_nl | m_s2;
                m_s2 = m_s1;
                m_s1 = sw;
`endif
                m_led = m_nl;
            end
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin
        logic [N-1:0] eg;
        forever begin
            @(negedge clk);
            eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            chk("model_grant", 32'(grant), 32'(eg));
            chk("model_busy", 32'(busy), 32'(m_owner >= 0));
            chk("model_led", 32'(led), 32'(m_led));
        end
    end

    logic [N-1:0] rr_exp [5];
    logic [N-1:0] vec [8];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        vec[0] = 4'b0110; vec[1] = 4'b0110; vec[2] = 4'b0000;
        vec[3] = 4'b1001; vec[4] = 4'b1111; vec[5] = 4'b0100;
        vec[6] = 4'b0000; vec[7] = 4'b1010;

        rst_n = 1'b0; sw = 1'b0; req = '0; led_val = '0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // basic grant, released at tenure 6
        req = 4'b0001; led_val = 4'b0001;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_led_lat", 32'(led), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_led", 32'(led), 32'h1);
        repeat (4) tick();
        req = '0;
        tick();
        chk("t1_gap_grant", 32'(grant), 32'h0);
        chk("t1_gap_led", 32'(led), 32'h0);
        chk("t1_gap_busy", 32'(busy), 32'h0);
        tick();
        chk("t1_idle", 32'(grant), 32'h0);

        // early drop held to hold time
        req = 4'b0100;
        tick();
        req = '0;
        chk("t2_grant1", 32'(grant), 32'h4);
        repeat (3) tick();
        chk("t2_grant4", 32'(grant), 32'h4);
        tick();
        chk("t2_gap", 32'(grant), 32'h0);
        tick();
        chk("t2_idle", 32'(busy), 32'h0);

        // round-robin under full load, each tenure times out
        do_reset();
        led_val = 4'b0101;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t3_first", 32'(grant), 32'(rr_exp[g]));
            repeat (9) tick();
            chk("t3_last", 32'(grant), 32'(rr_exp[g]));
            if (g == 4) req = '0;
            tick();
            chk("t3_gap", 32'(grant), 32'h0);
        end
        tick();

        // timeout hands over to the late requester
        do_reset();
        led_val = 4'b1111;
        req = 4'b0010;
        tick();
        chk("t4_grant", 32'(grant), 32'h2);
        repeat (3) tick();
        req = 4'b1010;
        repeat (6) tick();
        chk("t4_ten10", 32'(grant), 32'h2);
        tick();
        chk("t4_gap", 32'(grant), 32'h0);
        tick();
        chk("t4_next", 32'(grant), 32'h8);
        tick();
        chk("t5_led_pre", 32'(led), 32'h1);

        // asynchronous reset in the middle of a grant
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_led", 32'(led), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        tick();
        req = 4'b1001;
        rst_n = 1'b1;
        tick();
        chk("t5_ptr", 32'(grant), 32'h1);

        // directed vector sweep checked by the model
        for (int i = 0; i < 48; i++) begin
            req = vec[(i / 3) % 8];
            led_val = N'(i * 5);
            tick();
        end

`ifdef LED_ARB_SWITCH_OVERRIDE_EN
        do_reset();
        sw = 1'b1;
        tick();
        chk("t6_led1", 32'(led), 32'h0);
        tick();
        chk("t6_led2", 32'(led), 32'h0);
        tick();
        chk("t6_led3", 32'(led), 32'h1);
        led_val = '0;
        req = 4'b0010;
        tick();
        chk("t6_grant", 32'(grant), 32'h2);
        repeat (3) tick();
        chk("t6_led_hold", 32'(led), 32'h1);
        sw = 1'b0;
        req = '0;
        repeat (8) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
